// File: rtl/elevator_scheduler.sv
// Elevator request scheduler: latches floor calls, picks the next target
// floor and travel direction, and counts serviced requests.
module elevator_scheduler #(
    parameter int NUM_FLOORS = 7,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       call_req,
    input  logic [2:0]       current,
    input  logic             door_open,
    output logic [2:0]       sel,
    output logic             direction,
    output logic [6:0]       pending,
    output logic             idle,
    output logic [CNT_W-1:0] served_count
);

    localparam logic [6:0] FLOOR_MASK = 7'((1 << NUM_FLOORS) - 1);
    localparam logic [2:0] NO_TARGET  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] sel_nx;
    logic       dir_nx;

    logic       valid;
    logic [6:0] cur_bit;
    logic [6:0] above_m;
    logic [6:0] below_m;
    logic       above;
    logic       here;
    logic       below;
    logic [2:0] up_t;
    logic [2:0] down_t;
    logic       serve;
    logic [6:0] clr;
    logic [6:0] pending_nx;

    // current==7 shifts the single bit out, so an invalid floor selects nothing
    assign valid   = (current != 3'd7);
    assign cur_bit = 7'd1 << current;

    always_comb begin
        above_m = '0;
        below_m = '0;
        for (int i = 0; i < 7; i++) begin
            above_m[i] = (3'(i) > current);
            below_m[i] = (3'(i) < current);
        end
    end

    assign above = |(pending & above_m);
    assign here  = |(pending & cur_bit);
    assign below = |(pending & below_m);

    // Nearest pending floor on each side of the car
    always_comb begin
        up_t   = NO_TARGET;
        down_t = NO_TARGET;
        for (int i = 6; i >= 0; i--) begin
            if (pending[i] && above_m[i]) begin
                up_t = 3'(i);
            end
        end
        for (int i = 0; i < 7; i++) begin
            if (pending[i] && below_m[i]) begin
                down_t = 3'(i);
            end
        end
    end

    assign clr        = door_open ? cur_bit : 7'd0;
    assign serve      = door_open && here;
    assign pending_nx = (pending | (call_req & FLOOR_MASK)) & ~clr;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        dir_nx   = direction;
        if (valid) begin
            unique case (state)
                IDLE: begin
                    if (above) begin
                        state_nx = UP;
                    end else if (below) begin
                        state_nx = DOWN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                UP: begin
                    if (above || here) begin
                        state_nx = UP;
                    end else if (below) begin
                        state_nx = DOWN;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                DOWN: begin
                    if (below || here) begin
                        state_nx = DOWN;
                    end else if (above) begin
                        state_nx = UP;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase

            // Target follows the state being entered, not the one being left
            if (here) begin
                sel_nx = current;
            end else begin
                unique case (state_nx)
                    UP:      sel_nx = up_t;
                    DOWN:    sel_nx = down_t;
                    default: sel_nx = NO_TARGET;
                endcase
            end

            unique case (state_nx)
                UP:      dir_nx = 1'b0;
                DOWN:    dir_nx = 1'b1;
                default: dir_nx = direction;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= NO_TARGET;
            direction <= 1'b0;
        end else begin
            state     <= state_nx;
            sel       <= sel_nx;
            direction <= dir_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served_count <= '0;
        end else if (serve && (served_count != {CNT_W{1'b1}})) begin
            served_count <= served_count + 1'b1;
        end
    end

    assign idle = (state == IDLE);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random traffic
// compared against a floor-list reference model.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] call_req = '0;
    logic [2:0] current = 3'd0;
    logic       door_open = 1'b0;

    logic [2:0] sel;
    logic       direction;
    logic [6:0] pending;
    logic       idle;
    logic [7:0] served_count;

    logic [2:0] sel2;
    logic       direction2;
    logic [6:0] pending2;
    logic       idle2;
    logic [1:0] served_count2;

    int checks = 0;
    int errors = 0;

    // Reference model: floor list, motion mode (0 idle, 1 up, 2 down)
    int m_floor_req [7];
    int m_mode;
    int m_sel;
    int m_dir;
    int m_served;

    always #5 clk = ~clk;

    elevator_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .current      (current),
        .door_open    (door_open),
        .sel          (sel),
        .direction    (direction),
        .pending      (pending),
        .idle         (idle),
        .served_count (served_count)
    );

    elevator_scheduler #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .call_req     (call_req),
        .current      (current),
        .door_open    (door_open),
        .sel          (sel2),
        .direction    (direction2),
        .pending      (pending2),
        .idle         (idle2),
        .served_count (served_count2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [6:0] c,
                              input int cu, input logic d);
        int n_above;
        int n_below;
        int here;
        int lo_above;
        int hi_below;
        if (r) begin
            foreach (m_floor_req[f]) m_floor_req[f] = 0;
            m_mode   = 0;
            m_sel    = 7;
            m_dir    = 0;
            m_served = 0;
            return;
        end
        if (cu != 7) begin
            n_above  = 0;
            n_below  = 0;
            lo_above = 7;
            hi_below = 7;
            for (int f = 0; f < 7; f++) begin
                if (m_floor_req[f] != 0 && f > cu) begin
                    n_above++;
                    if (lo_above == 7) lo_above = f;
                end
                if (m_floor_req[f] != 0 && f < cu) begin
                    n_below++;
                    hi_below = f;
                end
            end
            here = m_floor_req[cu];
            case (m_mode)
                0: m_mode = (n_above > 0) ? 1 : (n_below > 0) ? 2 : 0;
                1: m_mode = (n_above > 0 || here != 0) ? 1 :
                            (n_below > 0) ? 2 : 0;
                default: m_mode = (n_below > 0 || here != 0) ? 2 :
                                  (n_above > 0) ? 1 : 0;
            endcase
            if (here != 0) m_sel = cu;
            else if (m_mode == 1) m_sel = lo_above;
            else if (m_mode == 2) m_sel = hi_below;
            else m_sel = 7;
            if (m_mode == 1) m_dir = 0;
            if (m_mode == 2) m_dir = 1;
            if (d && m_floor_req[cu] != 0) m_served++;
        end
        for (int f = 0; f < 7; f++) begin
            if (d && cu == f) m_floor_req[f] = 0;
            else if (c[f]) m_floor_req[f] = 1;
        end
    endtask

    function automatic int model_lamps();
        int v = 0;
        for (int f = 0; f < 7; f++) v += m_floor_req[f] * (1 << f);
        return v;
    endfunction

    task automatic cyc(input logic r, input logic [6:0] c,
                       input logic [2:0] cu, input logic d);
        reset     = r;
        call_req  = c;
        current   = cu;
        door_open = d;
        model_step(r, c, int'(cu), d);
        @(posedge clk);
        #1;
        check("sel", int'(sel), m_sel);
        check("direction", int'(direction), m_dir);
        check("pending", int'(pending), model_lamps());
        check("idle", int'(idle), (m_mode == 0) ? 1 : 0);
        check("served", int'(served_count),
              (m_served > 255) ? 255 : m_served);
        check("served_w2", int'(served_count2),
              (m_served > 3) ? 3 : m_served);
    endtask

    initial begin
        logic [6:0] rc;
        logic [2:0] rcur;

        // Idle after reset, no calls
        cyc(1'b1, 7'd0, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 7'd0, 3'd0, 1'b0);
            check("rst_sel", int'(sel), 7);
            check("rst_idle", int'(idle), 1);
        end

        // Call to the top floor from the ground
        cyc(1'b0, 7'b1000000, 3'd0, 1'b0);
        check("top_pend", int'(pending), 64);
        check("top_idle_n1", int'(idle), 1);
        cyc(1'b0, 7'd0, 3'd0, 1'b0);
        check("top_sel", int'(sel), 6);
        check("top_dir", int'(direction), 0);
        check("top_idle", int'(idle), 0);

        // Going up with requests on both sides, then reversal
        cyc(1'b1, 7'd0, 3'd0, 1'b0);
        cyc(1'b0, 7'b0100010, 3'd3, 1'b0);
        cyc(1'b0, 7'd0, 3'd3, 1'b0);
        check("rev_sel5", int'(sel), 5);
        check("rev_up", int'(direction), 0);
        cyc(1'b0, 7'd0, 3'd5, 1'b1);
        check("rev_pend", int'(pending), 2);
        check("rev_cnt", int'(served_count), 1);
        cyc(1'b0, 7'd0, 3'd5, 1'b0);
        check("rev_sel1", int'(sel), 1);
        check("rev_down", int'(direction), 1);
        check("rev_busy", int'(idle), 0);

        // Clear beats a simultaneous call at the open floor
        cyc(1'b1, 7'd0, 3'd0, 1'b0);
        cyc(1'b0, 7'b0000100, 3'd2, 1'b1);
        check("clr_win_pend", int'(pending), 0);
        check("clr_win_cnt", int'(served_count), 0);

        // Invalid floor: latch but hold scheduling
        cyc(1'b1, 7'd0, 3'd0, 1'b0);
        cyc(1'b0, 7'b0010000, 3'd7, 1'b1);
        check("inv_pend", int'(pending), 16);
        cyc(1'b0, 7'd0, 3'd7, 1'b0);
        check("inv_sel", int'(sel), 7);
        cyc(1'b0, 7'd0, 3'd4, 1'b0);
        check("inv_here_sel", int'(sel), 4);
        check("inv_here_idle", int'(idle), 1);

        // Counter saturation on the narrow instance, then mid-run reset
        cyc(1'b1, 7'd0, 3'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 7'd1 << k, 3'(k), 1'b0);
            cyc(1'b0, 7'd0, 3'(k), 1'b1);
        end
        check("sat_w2", int'(served_count2), 3);
        check("sat_w8", int'(served_count), 5);
        cyc(1'b0, 7'b1100001, 3'd3, 1'b0);
        cyc(1'b0, 7'd0, 3'd3, 1'b0);
        cyc(1'b1, 7'b0001000, 3'd3, 1'b1);
        check("mrst_pend", int'(pending), 0);
        check("mrst_sel", int'(sel), 7);
        check("mrst_dir", int'(direction), 0);
        check("mrst_idle", int'(idle), 1);
        check("mrst_cnt", int'(served_count2), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rc   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
            rcur = ($urandom_range(0, 9) == 0) ? 3'd7
                                               : 3'($urandom_range(0, 6));
            cyc(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rc, rcur,
                ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
